// File: rtl/fir_serial.sv
// fir_serial: time-multiplexed FIR filter sharing one multiply-accumulate across all taps.
// Run-time programmable coefficients; rounded, saturated output behind valid/ready handshakes.
module fir_serial #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam int RW     = ACC_W + 1;

  localparam logic signed [RW-1:0] RND = RW'((RW'(1) << SHIFT) >> 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic signed [DATA_W-1:0] hist_reg  [TAPS];
  logic signed [DATA_W-1:0] hist_next [TAPS];
  logic signed [COEF_W-1:0] coef_reg  [TAPS];
  logic signed [COEF_W-1:0] coef_next [TAPS];

  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [AW-1:0]            idx_reg;
  logic signed [DATA_W-1:0] hist_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [RW-1:0]     rnd_sum;
  logic signed [RW-1:0]     shifted;
  logic signed [OUT_W-1:0]  res_data;
  logic                     res_sat;
  logic signed [OUT_W-1:0]  out_data_reg;
  logic                     out_sat_reg;

  logic accept;
  logic coef_wr;
  logic last_tap;

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        if (idx_reg == AW'(TAPS - 1)) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept   = (state_reg == IDLE) && in_valid;
  assign coef_wr  = (state_reg == IDLE) && coef_we && (32'(coef_addr) < TAPS);
  assign last_tap = (state_reg == MAC) && (idx_reg == AW'(TAPS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign hist_next[gi] = accept ? in_data : hist_reg[gi];
      end else begin : g_body
        assign hist_next[gi] = accept ? hist_reg[gi-1] : hist_reg[gi];
      end
      assign coef_next[gi] = (coef_wr && (coef_addr == AW'(gi))) ? coef_data : coef_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        hist_reg[k] <= '0;
        coef_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        hist_reg[k] <= hist_next[k];
        coef_reg[k] <= coef_next[k];
      end
    end
  end

  // Single shared multiplier: one tap per MAC cycle, selected by idx.
  assign hist_sel = hist_reg[idx_reg];
  assign coef_sel = coef_reg[idx_reg];
  assign prod     = PROD_W'(hist_sel) * PROD_W'(coef_sel);
  assign acc_sum  = acc_reg + ACC_W'(prod);

  // One guard bit keeps the rounding offset from wrapping the accumulator.
  assign rnd_sum = RW'(acc_sum) + RND;
  assign shifted = rnd_sum >>> SHIFT;

  generate
    if (OUT_W >= RW) begin : g_nosat
      assign res_data = OUT_W'(shifted);
      assign res_sat  = 1'b0;
    end else begin : g_sat
      localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        res_data = shifted[OUT_W-1:0];
        res_sat  = 1'b0;
        if (shifted > SAT_MAX) begin
          res_data = SAT_MAX[OUT_W-1:0];
          res_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
          res_data = SAT_MIN[OUT_W-1:0];
          res_sat  = 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      idx_reg      <= '0;
      out_data_reg <= '0;
      out_sat_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (state_reg == MAC) begin
        acc_reg <= acc_sum;
        idx_reg <= idx_reg + AW'(1);
      end
      // Result is captured from the final sum, so it is ready the cycle OUT begins.
      if (last_tap) begin
        out_data_reg <= res_data;
        out_sat_reg  <= res_sat;
      end
    end
  end

  assign out_data = out_data_reg;
  assign out_sat  = out_sat_reg;

endmodule

// File: tb/tb_fir_serial.sv
// tb_fir_serial: two filter instances (SHIFT=0 and SHIFT=12) share one stimulus stream and
// are checked against a sum-of-products reference model plus fixed expected values.
`timescale 1ns/1ps
module tb_fir_serial;
  localparam int TAPS   = 16;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int OUT_W  = 24;
  localparam int SH_B   = 12;
  localparam int AW     = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic coef_we = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic [AW-1:0] coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;

  logic a_in_ready, a_out_valid, a_out_sat, a_busy;
  logic b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic signed [OUT_W-1:0] a_out_data, b_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  longint m_hist [TAPS];
  longint m_coef [TAPS];

  int lat;
  logic ov;
  logic signed [OUT_W-1:0] od_a, od_b, ex_a, ex_b;
  logic os_a, os_b, es_a, es_b;

  fir_serial #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_sat(a_out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(a_busy)
  );

  fir_serial #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SH_B)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_sat(b_out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_hist[k] = 0;
      m_coef[k] = 0;
    end
  endtask

  task automatic model_push(input longint x);
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = x;
  endtask

  // Reference: plain dot product, round half up, clip to OUT_W.
  function automatic logic signed [OUT_W-1:0] model_out(input int sh, output logic sat);
    longint s, r, hi, lo;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += m_hist[k] * m_coef[k];
    r = s;
    if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -hi - 1;
    sat = 1'b0;
    if (r > hi) begin
      sat = 1'b1;
      r = hi;
    end else if (r < lo) begin
      sat = 1'b1;
      r = lo;
    end
    return OUT_W'(r);
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    coef_we = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic write_coef(input int a, input longint d);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    tick();
    coef_we = 1'b0;
    m_coef[a] = d;
  endtask

  task automatic accept_sample(input longint x);
    int w;
    w = 0;
    while (a_in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    in_valid = 1'b1;
    in_data = DATA_W'(x);
    tick();
    in_valid = 1'b0;
    model_push(x);
  endtask

  // lat counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int pre);
    lat = pre;
    while (a_out_valid !== 1'b1 && lat < 4 * TAPS) begin
      tick();
      lat++;
    end
    ov = a_out_valid & b_out_valid;
    od_a = a_out_data;
    os_a = a_out_sat;
    od_b = b_out_data;
    os_b = b_out_sat;
    ex_a = model_out(0, es_a);
    ex_b = model_out(SH_B, es_b);
    $display("tx in=%0d lat=%0d out_a=%0d sat_a=%0b out_b=%0d sat_b=%0b",
             m_hist[0], lat, od_a, os_a, od_b, os_b);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({a_in_ready, b_in_ready, a_busy, b_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_ready_busy: got %b want 1100", {a_in_ready, b_in_ready, a_busy, b_busy});
    end
    n_checks++;
    if ({a_out_valid, b_out_valid, a_out_sat, b_out_sat} !== 4'b0000 || a_out_data !== '0 || b_out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b%b s=%b%b d=%0d/%0d want all zero",
               a_out_valid, b_out_valid, a_out_sat, b_out_sat, a_out_data, b_out_data);
    end
    rst = 1'b1;
    tick();
    model_reset();
    n_checks++;
    if ({a_in_ready, b_in_ready, a_busy, b_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL release_idle: got %b want 1100", {a_in_ready, b_in_ready, a_busy, b_busy});
    end

    write_coef(0, 5);
    accept_sample(100);
    wait_out(0);
    n_checks++;
    if (od_a !== OUT_W'(500) || os_a !== 1'b0 || od_b !== ex_b || os_b !== es_b) begin
      n_fail++;
      $display("FAIL pre_reset_out: got %0d/%0d want 500/%0d", od_a, od_b, ex_b);
    end
    release_out();

    // Asynchronous reset in the middle of a MAC pass.
    accept_sample(3);
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a_in_ready, b_in_ready, a_busy, b_busy, a_out_valid, b_out_valid} !== 6'b110000) begin
      n_fail++;
      $display("FAIL midrun_reset_ctrl: got %b want 110000",
               {a_in_ready, b_in_ready, a_busy, b_busy, a_out_valid, b_out_valid});
    end
    n_checks++;
    if (a_out_data !== '0 || b_out_data !== '0 || a_out_sat !== 1'b0 || b_out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_data: got %0d/%0d want 0/0", a_out_data, b_out_data);
    end
    tick();
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      accept_sample((i == 0) ? 1 : 0);
      wait_out(0);
      n_checks++;
      if (od_a !== '0 || od_b !== '0 || os_a !== 1'b0 || os_b !== 1'b0 || ov !== 1'b1) begin
        n_fail++;
        $display("FAIL cleared_coef[%0d]: got %0d/%0d valid=%b want 0/0 valid=1", i, od_a, od_b, ov);
      end
      release_out();
    end
  endtask

  task automatic test_impulse();
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int k = 0; k < TAPS; k++) begin
      accept_sample((k == 0) ? 1 : 0);
      wait_out(0);
      n_checks++;
      if (lat !== TAPS || ov !== 1'b1) begin
        n_fail++;
        $display("FAIL impulse_latency[%0d]: got %0d edges valid=%b want %0d edges", k, lat, ov, TAPS);
      end
      n_checks++;
      if (od_a !== OUT_W'(k + 1) || os_a !== 1'b0) begin
        n_fail++;
        $display("FAIL impulse_a[%0d]: got %0d sat=%b want %0d sat=0", k, od_a, os_a, k + 1);
      end
      n_checks++;
      if (od_b !== ex_b || os_b !== es_b) begin
        n_fail++;
        $display("FAIL impulse_b[%0d]: got %0d want %0d", k, od_b, ex_b);
      end
      release_out();
    end
  endtask

  task automatic test_rounding();
    longint rin  [2] = '{1000, -1000};
    longint rexp [2] = '{532, -532};
    do_reset();
    write_coef(0, 2178);
    for (int i = 0; i < 2; i++) begin
      accept_sample(rin[i]);
      wait_out(0);
      n_checks++;
      if (od_b !== OUT_W'(rexp[i]) || os_b !== 1'b0) begin
        n_fail++;
        $display("FAIL rounding_b[%0d]: got %0d sat=%b want %0d sat=0", i, od_b, os_b, rexp[i]);
      end
      n_checks++;
      if (od_a !== ex_a || os_a !== es_a) begin
        n_fail++;
        $display("FAIL rounding_a[%0d]: got %0d want %0d", i, od_a, ex_a);
      end
      release_out();
    end
  endtask

  task automatic test_saturation();
    longint x;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int p = 0; p < 2; p++) begin
      x = (p == 0) ? 32767 : -32768;
      for (int i = 0; i < TAPS; i++) begin
        accept_sample(x);
        wait_out(0);
        n_checks++;
        if (od_a !== ex_a || os_a !== es_a || od_b !== ex_b || os_b !== es_b) begin
          n_fail++;
          $display("FAIL sat_model[%0d.%0d]: got %0d/%b %0d/%b want %0d/%b %0d/%b",
                   p, i, od_a, os_a, od_b, os_b, ex_a, es_a, ex_b, es_b);
        end
        release_out();
      end
      n_checks++;
      if (od_a !== ((p == 0) ? OUT_W'(8388607) : OUT_W'(-8388608)) || os_a !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_limit[%0d]: got %0d sat=%b want %0d sat=1",
                 p, od_a, os_a, (p == 0) ? 8388607 : -8388608);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [OUT_W-1:0] held_a, held_b;
    accept_sample(1234);
    wait_out(0);
    held_a = od_a;
    held_b = od_b;
    n_checks++;
    if (od_a !== ex_a || od_b !== ex_b) begin
      n_fail++;
      $display("FAIL bp_first: got %0d/%0d want %0d/%0d", od_a, od_b, ex_a, ex_b);
    end
    in_valid = 1'b1;
    in_data = 16'sd777;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1 || a_out_data !== held_a || b_out_data !== held_b ||
          a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b%b rdy=%b%b d=%0d/%0d want v=11 rdy=00 d=%0d/%0d",
                 c, a_out_valid, b_out_valid, a_in_ready, b_in_ready, a_out_data, b_out_data, held_a, held_b);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({a_in_ready, b_in_ready, a_out_valid, b_out_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL bp_release: got %b want 1100", {a_in_ready, b_in_ready, a_out_valid, b_out_valid});
    end
    tick();
    in_valid = 1'b0;
    model_push(777);
    n_checks++;
    if ({a_busy, b_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_accept: got busy=%b want 11", {a_busy, b_busy});
    end
    wait_out(0);
    n_checks++;
    if (lat !== TAPS || od_a !== ex_a || od_b !== ex_b || os_a !== es_a || os_b !== es_b) begin
      n_fail++;
      $display("FAIL bp_second: got lat=%0d %0d/%0d want lat=%0d %0d/%0d", lat, od_a, od_b, TAPS, ex_a, ex_b);
    end
    release_out();
  endtask

  task automatic test_busy_write();
    do_reset();
    write_coef(0, 10);
    write_coef(1, -3);
    accept_sample(50);
    tick();
    tick();
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = 16'sd999;
    tick();
    coef_we = 1'b0;
    wait_out(3);
    n_checks++;
    if (lat !== TAPS || od_a !== OUT_W'(500) || od_b !== ex_b) begin
      n_fail++;
      $display("FAIL busywr_current: got lat=%0d %0d/%0d want lat=%0d 500/%0d", lat, od_a, od_b, TAPS, ex_b);
    end
    release_out();
    accept_sample(-20);
    wait_out(0);
    n_checks++;
    if (od_a !== OUT_W'(-350) || od_b !== ex_b) begin
      n_fail++;
      $display("FAIL busywr_next: got %0d/%0d want -350/%0d", od_a, od_b, ex_b);
    end
    release_out();
    // Write and accept in the same idle cycle: the new coefficient applies immediately.
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = 16'sd999;
    in_valid = 1'b1;
    in_data = 16'sd7;
    tick();
    coef_we = 1'b0;
    in_valid = 1'b0;
    m_coef[0] = 999;
    model_push(7);
    wait_out(0);
    n_checks++;
    if (od_a !== OUT_W'(7053) || od_b !== ex_b) begin
      n_fail++;
      $display("FAIL idlewr_applied: got %0d/%0d want 7053/%0d", od_a, od_b, ex_b);
    end
    release_out();
  endtask

  task automatic test_random();
    logic signed [15:0] r16;
    int pre;
    int hold;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        r16 = 16'($urandom);
        write_coef(int'($urandom_range(0, TAPS - 1)), r16);
      end
      r16 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r16 = 16'sh8000;
      accept_sample(r16);
      pre = 0;
      if ($urandom_range(0, 2) == 0) begin
        coef_we = 1'b1;
        coef_addr = AW'($urandom_range(0, TAPS - 1));
        coef_data = 16'($urandom);
        tick();
        coef_we = 1'b0;
        pre = 1;
      end
      wait_out(pre);
      n_checks++;
      if (lat !== TAPS || ov !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_latency[%0d]: got %0d valid=%b want %0d", i, lat, ov, TAPS);
      end
      n_checks++;
      if (od_a !== ex_a || os_a !== es_a) begin
        n_fail++;
        $display("FAIL rand_a[%0d]: got %0d/%b want %0d/%b", i, od_a, os_a, ex_a, es_a);
      end
      n_checks++;
      if (od_b !== ex_b || os_b !== es_b) begin
        n_fail++;
        $display("FAIL rand_b[%0d]: got %0d/%b want %0d/%b", i, od_b, os_b, ex_b, es_b);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      n_checks++;
      if (a_out_data !== od_a || b_out_data !== od_b || a_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_hold[%0d]: got %0d/%0d v=%b want %0d/%0d v=1",
                 i, a_out_data, b_out_data, a_out_valid, od_a, od_b);
      end
      release_out();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_busy_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
